// File: rtl/demux_stream_nch.sv
// demux_stream_nch: 1-to-N valid/ready stream demultiplexer with one FIFO per
// output channel, optional broadcast to every channel, and a saturating count
// of words sunk because their select addressed a channel that does not exist.
module demux_stream_nch #(
  parameter int unsigned DW    = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [$clog2(N)-1:0] in_sel,
  input  logic                 in_bcast,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*DW-1:0]      out_data,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned SW = $clog2(N);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem  [N][DEPTH];
  logic [AW-1:0] wptr [N];
  logic [AW-1:0] rptr [N];
  logic [CW-1:0] cnt  [N];

  logic [N-1:0] full;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic         sel_ok;
  logic         sel_full;
  logic         accept;
  logic         drop;

  // Per-channel status and lookup of the addressed channel (no out-of-range index)
  always_comb begin
    full      = '0;
    out_valid = '0;
    sel_ok    = 1'b0;
    sel_full  = 1'b0;
    for (int k = 0; k < N; k++) begin
      full[k]      = (cnt[k] == CW'(DEPTH));
      out_valid[k] = (cnt[k] != '0);
      if (in_sel == SW'(k)) begin
        sel_ok   = 1'b1;
        sel_full = (cnt[k] == CW'(DEPTH));
      end
    end
  end

  // Input ready depends only on FIFO occupancy, never on out_ready
  always_comb begin
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = ~|full;
    end else if (sel_ok) begin
      in_ready = ~sel_full;
    end else begin
      in_ready = 1'b1;
    end
  end

  // Push/pop strobes; a broadcast pushes every channel on the same edge
  always_comb begin
    accept = in_valid & in_ready;
    drop   = accept & ~in_bcast & ~sel_ok;
    push   = '0;
    for (int k = 0; k < N; k++) begin
      push[k] = accept & (in_bcast | (sel_ok & (in_sel == SW'(k))));
    end
    pop = out_valid & out_ready;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (push[k]) begin
          wptr[k] <= wptr[k] + AW'(1);
        end
        if (pop[k]) begin
          rptr[k] <= rptr[k] + AW'(1);
        end
        if (push[k] && !pop[k]) begin
          cnt[k] <= cnt[k] + CW'(1);
        end else if (!push[k] && pop[k]) begin
          cnt[k] <= cnt[k] - CW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are qualified by cnt so no reset is needed
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (push[k]) begin
        mem[k][wptr[k]] <= in_data;
      end
    end
  end

  // Head word per channel, forced to zero when the channel is empty
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      if (out_valid[k]) begin
        out_data[k*DW +: DW] = mem[k][rptr[k]];
      end
    end
  end

  // Saturating count of words sunk for a non-existent channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
